// File: rtl/pio_input_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pio_input_edge_capture
//  Purpose  : Avalon-MM input PIO. Synchronises and debounces an external
//             parallel bus, captures selected edges in sticky bits and raises
//             a maskable level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_input_edge_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int         c_CNT_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             w_rd_en;
    logic             w_wr_en;
    logic             w_unused_wdata;

    assign w_rd_en        = chipselect & ~read_n;
    assign w_wr_en        = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous input bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign w_stable = r_sync2;
        end else begin : g_debounce
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [c_CNT_W-1:0] r_cnt;
                logic               r_stable_bit;

                // Any return to the accepted level restarts the count
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt        <= '0;
                        r_stable_bit <= 1'b0;
                    end else if (r_sync2[i] == r_stable_bit) begin
                        r_cnt        <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable_bit <= r_sync2[i];
                        r_cnt        <= '0;
                    end else begin
                        r_cnt        <= r_cnt + 1'b1;
                    end
                end

                assign w_stable[i] = r_stable_bit;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    assign w_rise = w_stable & ~r_stable_d;
    assign w_fall = ~w_stable & r_stable_d;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = w_fall;
        end else begin : g_edge_any
            assign w_edge = w_rise | w_fall;
        end
    endgenerate

    assign w_clear = (w_wr_en && (address == c_ADDR_EDGE)) ? w_wdata : '0;

    // A new edge overrides a clear of the same bit in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clear) | w_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr_en && (address == c_ADDR_MASK)) begin
            r_mask <= w_wdata;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_stable;
            c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
            c_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:     w_rd_mux = '0;
        endcase
    end

    // Mux uses pre-edge register values, so a combined read/write returns old data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd_en) begin
            r_readdata <= w_rd_mux;
        end else begin
            r_readdata <= '0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_pio_input_edge_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_input_edge_capture
//  Purpose  : Self-checking bench for pio_input_edge_capture (two configs:
//             D=3 falling-edge, and D=0 any-edge bypass).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pio_input_edge_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_input_edge_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(1)) u_dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_a), .in_port(in_port), .irq(irq_a)
    );

    pio_input_edge_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_b), .in_port(in_port), .irq(irq_b)
    );

    // Reference model: index 0 mirrors u_dut_a's configuration, index 1 u_dut_b's
    logic [3:0]  m_s1 [2];
    logic [3:0]  m_s2 [2];
    logic [3:0]  m_st [2];
    logic [3:0]  m_sd [2];
    logic [3:0]  m_ec [2];
    logic [3:0]  m_mk [2];
    logic [31:0] m_rd [2];
    int          m_streak [2][4];

    function automatic int md(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int et(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    always @(posedge clk) begin
        logic [3:0]  st_n;
        logic [3:0]  ed;
        logic [3:0]  clr;
        logic [31:0] rd_n;
        int          str_n;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_s1[k] <= '0; m_s2[k] <= '0; m_st[k] <= '0; m_sd[k] <= '0;
                m_ec[k] <= '0; m_mk[k] <= '0; m_rd[k] <= '0;
                for (int b = 0; b < 4; b++) m_streak[k][b] <= 0;
            end else begin
                st_n = m_st[k];
                for (int b = 0; b < 4; b++) begin
                    if (md(k) == 0) begin
                        st_n[b] = m_s1[k][b];
                    end else begin
                        // accept the new level once it has disagreed for md(k) cycles in a row
                        str_n = (m_s2[k][b] != m_st[k][b]) ? m_streak[k][b] + 1 : 0;
                        if (str_n == md(k)) begin
                            st_n[b] = m_s2[k][b];
                            str_n   = 0;
                        end
                        m_streak[k][b] <= str_n;
                    end
                end
                if (et(k) == 0)      ed = m_st[k] & ~m_sd[k];
                else if (et(k) == 1) ed = ~m_st[k] & m_sd[k];
                else                 ed = m_st[k] ^ m_sd[k];
                clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
                rd_n = 32'h0;
                if (chipselect && !read_n) begin
                    if (address == 2'd0)      rd_n = {28'h0, m_st[k]};
                    else if (address == 2'd2) rd_n = {28'h0, m_mk[k]};
                    else if (address == 2'd3) rd_n = {28'h0, m_ec[k]};
                end
                if (chipselect && !write_n && address == 2'd2) m_mk[k] <= writedata[3:0];
                m_ec[k] <= (m_ec[k] & ~clr) | ed;
                m_rd[k] <= rd_n;
                m_sd[k] <= m_st[k];
                m_st[k] <= st_n;
                m_s2[k] <= m_s1[k];
                m_s1[k] <= in_port;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic cs, input logic rn, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs; read_n = rn; write_n = wn; address = a; writedata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = 4'hF; idle();
        ticks(2);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a)); tick();
            checks++;
            if (rd_a !== 32'h0 || irq_a !== 1'b0 || rd_b !== 32'h0 || irq_b !== 1'b0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got a=%h/%b b=%h/%b exp 0/0", a, rd_a, irq_a, rd_b, irq_b);
            end
        end
        reset = 1'b0; idle();
        ticks(4);
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'hF) begin
            failures++;
            $display("FAIL release_edge5_data got a=%h b=%h exp a=0 b=f", rd_a, rd_b);
        end
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'hF) begin
            failures++; $display("FAIL release_edge6_data got=%h exp=0000000f", rd_a);
        end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'hF || irq_b !== 1'b0) begin
            failures++;
            $display("FAIL release_rising_capture got a=%h b=%h irq_b=%b exp a=0 b=f irq_b=0", rd_a, rd_b, irq_b);
        end
        wr(2'd3, 32'hF); tick();
    endtask

    task automatic test_debounce();
        in_port = 4'h0; idle(); ticks(10);
        wr(2'd3, 32'hF); tick();
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL deb_settle_low got=%h exp=0", rd_a); end
        in_port = 4'h1; idle(); ticks(2);
        in_port = 4'h0; ticks(8);
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL deb_glitch_data got=%h exp=0", rd_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'h1) begin
            failures++; $display("FAIL deb_glitch_capture got a=%h b=%h exp a=0 b=1", rd_a, rd_b);
        end
        wr(2'd3, 32'hF); tick();
        in_port = 4'h1; idle(); ticks(4);
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL deb_edge5_early got=%h exp=0", rd_a); end
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("FAIL deb_edge5_accept got=%h exp=1", rd_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL deb_rise_ignored got=%h exp=0", rd_a); end
    endtask

    task automatic test_falling_irq();
        wr(2'd2, 32'h1); tick();
        idle(); ticks(2);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL fall_irq_idle got=%b exp=0", irq_a); end
        in_port = 4'h0; ticks(5);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL fall_irq_edge5 got=%b exp=0", irq_a); end
        tick();
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("FAIL fall_irq_edge6 got=%b exp=1", irq_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h1) begin failures++; $display("FAIL fall_capture got=%h exp=1", rd_a); end
        wr(2'd3, 32'h1); tick();
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL fall_clear_irq got=%b exp=0", irq_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL fall_clear_capture got=%h exp=0", rd_a); end
    endtask

    task automatic test_mask();
        wr(2'd2, 32'h0); tick();
        wr(2'd3, 32'hF); tick();
        in_port = 4'h4; idle(); ticks(8);
        wr(2'd3, 32'hF); tick();
        in_port = 4'h0; idle(); ticks(8);
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h4 || irq_a !== 1'b0) begin
            failures++; $display("FAIL mask_off got cap=%h irq=%b exp cap=4 irq=0", rd_a, irq_a);
        end
        wr(2'd2, 32'h4); tick();
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("FAIL mask_on_irq got=%b exp=1", irq_a); end
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h4) begin failures++; $display("FAIL mask_readback got=%h exp=4", rd_a); end
    endtask

    task automatic test_collision();
        wr(2'd3, 32'hF); tick();
        in_port = 4'h2; idle(); ticks(8);
        wr(2'd3, 32'hF); tick();
        in_port = 4'h0; idle(); ticks(5);
        wr(2'd3, 32'hF); tick();
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h2 || irq_a !== 1'b0) begin
            failures++; $display("FAIL collision_set_wins got cap=%h irq=%b exp cap=2 irq=0", rd_a, irq_a);
        end
    endtask

    task automatic test_reads();
        wr(2'd2, 32'hFFFF_FFF5); tick();
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h5) begin failures++; $display("FAIL read_mask_width got=%h exp=5", rd_a); end
        rd(2'd1); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL read_addr1 got=%h exp=0", rd_a); end
        in_port = 4'hA; idle(); ticks(8);
        rd(2'd0); tick();
        checks++;
        if (rd_a !== 32'hA) begin failures++; $display("FAIL b2b_data got=%h exp=a", rd_a); end
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h5) begin failures++; $display("FAIL b2b_mask got=%h exp=5", rd_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h2) begin failures++; $display("FAIL b2b_capture got=%h exp=2", rd_a); end
        drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h3); tick();
        checks++;
        if (rd_a !== 32'h5) begin failures++; $display("FAIL rw_mask_old got=%h exp=5", rd_a); end
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h3) begin failures++; $display("FAIL rw_mask_new got=%h exp=3", rd_a); end
        drive(1'b1, 1'b0, 1'b0, 2'd3, 32'h2); tick();
        checks++;
        if (rd_a !== 32'h2) begin failures++; $display("FAIL rw_cap_old got=%h exp=2", rd_a); end
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL rw_cap_new got=%h exp=0", rd_a); end
        idle(); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL idle_readdata got=%h exp=0", rd_a); end
        drive(1'b0, 1'b0, 1'b0, 2'd2, 32'hF); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL no_cs_read got=%h exp=0", rd_a); end
        wr(2'd0, 32'hF); tick();
        wr(2'd1, 32'hF); tick();
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h3) begin failures++; $display("FAIL ignored_writes got=%h exp=3", rd_a); end
    endtask

    task automatic test_mid_reset();
        wr(2'd2, 32'hF); tick();
        in_port = 4'h0; idle(); ticks(8);
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq_a); end
        in_port = 4'hF; ticks(3);
        reset = 1'b1; tick();
        checks++;
        if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
            failures++; $display("FAIL mid_reset_irq got a=%b b=%b exp 0", irq_a, irq_b);
        end
        reset = 1'b0;
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL mid_reset_capture got=%h exp=0", rd_a); end
        rd(2'd2); tick();
        checks++;
        if (rd_a !== 32'h0) begin failures++; $display("FAIL mid_reset_mask got=%h exp=0", rd_a); end
        idle(); ticks(2);
        rd(2'd3); tick();
        checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'hF) begin
            failures++; $display("FAIL held_high_rise got a=%h b=%h exp a=0 b=f", rd_a, rd_b);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold == 0) begin
                in_port = 4'($urandom_range(0, 15));
                hold    = $urandom_range(1, 8);
            end
            hold--;
            reset = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 5))
                0, 1:    idle();
                2:       rd(2'($urandom_range(0, 3)));
                3:       wr(2'($urandom_range(0, 3)), $urandom);
                4:       drive(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
                default: drive(1'b0, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), $urandom);
            endcase
            tick();
            checks++;
            if (rd_a !== m_rd[0] || irq_a !== |(m_ec[0] & m_mk[0])) begin
                failures++;
                $display("FAIL rand_a cyc=%0d got rd=%h irq=%b exp rd=%h irq=%b",
                         n, rd_a, irq_a, m_rd[0], |(m_ec[0] & m_mk[0]));
            end
            checks++;
            if (rd_b !== m_rd[1] || irq_b !== |(m_ec[1] & m_mk[1])) begin
                failures++;
                $display("FAIL rand_b cyc=%0d got rd=%h irq=%b exp rd=%h irq=%b",
                         n, rd_b, irq_b, m_rd[1], |(m_ec[1] & m_mk[1]));
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        in_port = 4'hF;
        idle();
        test_reset();
        test_debounce();
        test_falling_irq();
        test_mask();
        test_collision();
        test_reads();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_input_edge_capture.md
# pio_input_edge_capture

Avalon-MM slave input port: samples an external parallel bus (keys/switches), synchronizes and debounces each bit, latches selected edges in a sticky edge-capture register and raises a maskable level interrupt. It is the read-direction counterpart of the system's output PIO registers and sits on the same Avalon-MM fabric as those blocks, with the same 2-bit word address map style.

## Interface
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before a bit change is accepted; 0 = bypass
- EDGE_TYPE, 1, 0 = rising, 1 = falling, 2 = any edge

- clk  in  1  system clock; the block uses this single clock
- reset  in  1  synchronous, active-high reset
- address  in  2  word address: 0 data, 2 irq mask, 3 edge capture (1 unused)
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  level interrupt, high while any unmasked capture bit is set

## Operation
- Synchronizer: two flip-flops per bit (s1, s2); reset value of both = 0.
- Debounce, per bit, counter width ceil(log2(DEBOUNCE_CYCLES+1)):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - otherwise cnt <= cnt+1. A glitch shorter than DEBOUNCE_CYCLES resets cnt and never reaches stable.
  - DEBOUNCE_CYCLES = 0: stable is s2 directly.
- Edge detect: stable_d <= stable every cycle; rise = stable & ~stable_d, fall = ~stable & stable_d; edge per EDGE_TYPE.
- Edge capture (WIDTH bits, sticky): bit set on edge; write to address 3 clears bits where writedata = 1. Same-cycle edge and clear on one bit: set wins.
- IRQ mask (WIDTH bits): written at address 2; write to address 0 or 1 ignored.
- irq = |(edgecapture & mask), combinational from registers.
- Reads: address 0 returns stable (debounced data), 2 mask, 3 edgecapture, 1 returns 0; bits above WIDTH read 0. Reads have no side effects.
- Writes and reads require chipselect; write_n and read_n simultaneously low: write takes effect, readdata still returns pre-write register value.
- Reset values: s1, s2, stable, stable_d, cnt, mask, edgecapture, readdata = 0; irq = 0.

## Timing
- Read latency 1: readdata loaded at the clock edge where chipselect & ~read_n; otherwise readdata <= 0 on that edge. Zero wait states.
- Write takes effect at the edge where chipselect & ~write_n; a read in the next cycle sees the new value.
- in_port change sampled at edge 1 -> s2 at edge 2 -> stable at edge 2+D (D = DEBOUNCE_CYCLES) -> edgecapture and irq at edge 3+D.
- Reset asserted mid-count or with captures pending: all state cleared at that edge; irq low the following cycle; no edge reported from the reset-to-run transition (stable and stable_d both 0).
- An input held at 1 through reset produces a rising edge after release (stable 0 -> 1); this is required behaviour.

## Test plan
- Reset: drive in_port=4'hF during reset, check readdata=0 and irq=0 on every register read; release, read address 0 = 0x0000000F after 2+D cycles.
- Debounce: D=3, pulse in_port[0] high for 2 cycles -> address 0 bit 0 stays 0, no capture; hold 3+ cycles -> bit 0 = 1 exactly at edge 5 after change.
- Falling edge IRQ: EDGE_TYPE=1, mask=0x1, in_port[0] 1->0 -> edgecapture=0x1, irq=1 at edge 3+D; write 0x1 to address 3 -> edgecapture=0, irq=0 next cycle.
- Mask: mask=0x0, generate edge on bit 2 -> edgecapture=0x4, irq=0; write mask=0x4 -> irq=1 the following cycle.
- Set vs clear collision: time a write of 0xF to address 3 on the same edge bit 1 captures -> edgecapture bit 1 = 1 afterwards.
- Reads: address 1 -> 0; back-to-back reads of address 0, 2, 3 each return correct data one cycle later; read with write_n also low returns old value.
